bp_be_redirect_ctl: RTL

Sequencer behind the backend control pipe. Compares each resolved control-pipe packet (valid, branch, taken, next PC) against the PC the frontend predicted. On a mismatch it flushes younger work, holds a redirect to the frontend on a valid/ready handshake, then stalls issue for a programmable refill window. Sits between the calculator's control pipe and the FE command queue. Also keeps saturating branch and mispredict counters for performance reporting.

---
 rtl/bp_be_pkg.sv | 11 +
 rtl/bp_be_sat_counter.sv | 32 +++
 rtl/bp_be_redirect_ctl.sv | 108 ++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Shared types for the backend redirect sequencer.
package bp_be_pkg;

   // Redirect sequencer phases: watching packets, holding a redirect, refilling.
   typedef enum logic [1:0] {
      e_idle     = 2'd0,
      e_redirect = 2'd1,
      e_drain    = 2'd2
   } bp_be_redirect_state_e;

endpackage

// File: rtl/bp_be_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module bp_be_sat_counter #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               inc_i,
   output logic [width_p-1:0] count_o
);

   logic [width_p-1:0] count_q, count_d;

   // Next count: increment only while below the all-ones ceiling.
   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + width_p'(1);
      end
   end

   // Count register with synchronous active-low clear.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/bp_be_redirect_ctl.sv
// Backend redirect sequencer: detects next-PC mispredicts, flushes younger
// work, holds a redirect to the frontend until accepted, then stalls issue
// for a fixed refill window. Also keeps branch/mispredict perf counters.
module bp_be_redirect_ctl
   import bp_be_pkg::*;
#(
   parameter int vaddr_width_p  = 39,
   parameter int drain_cycles_p = 2,
   parameter int ctr_width_p    = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     br_v_i,
   input  logic                     br_branch_i,
   input  logic                     br_btaken_i,
   input  logic [vaddr_width_p-1:0] br_npc_i,
   input  logic [vaddr_width_p-1:0] expected_npc_i,
   output logic                     redirect_v_o,
   output logic [vaddr_width_p-1:0] redirect_npc_o,
   input  logic                     redirect_ready_i,
   output logic                     flush_o,
   output logic                     stall_o,
   output logic [ctr_width_p-1:0]   branch_count_o,
   output logic [ctr_width_p-1:0]   mispredict_count_o
);

   // The drain counter only ever holds values up to drain_cycles_p-1.
   localparam int drain_w_lp = (drain_cycles_p > 1) ? $clog2(drain_cycles_p) : 1;

   bp_be_redirect_state_e    state_q;
   logic [vaddr_width_p-1:0] target_q;
   logic [drain_w_lp-1:0]    drain_q;

   logic idle;
   logic mispredict;
   logic branch_inc;
   logic mispredict_inc;

   // Taken-ness is already folded into the resolved next PC, so the
   // comparison alone decides a mispredict.
   logic unused_btaken;
   assign unused_btaken = br_btaken_i;

   assign idle       = (state_q == e_idle);
   assign mispredict = br_v_i & (br_npc_i != expected_npc_i);

   // Packets seen outside idle are wrong-path and must not be counted.
   assign branch_inc     = idle & br_v_i & br_branch_i;
   assign mispredict_inc = idle & mispredict;

   // Sequencer: capture target on mispredict, wait for acceptance, then drain.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q  <= e_idle;
         target_q <= '0;
         drain_q  <= '0;
      end else begin
         case (state_q)
            e_idle: begin
               if (mispredict) begin
                  target_q <= br_npc_i;
                  state_q  <= e_redirect;
               end
            end
            e_redirect: begin
               if (redirect_ready_i) begin
                  if (drain_cycles_p > 0) begin
                     state_q <= e_drain;
                     drain_q <= drain_w_lp'(drain_cycles_p - 1);
                  end else begin
                     state_q <= e_idle;
                  end
               end
            end
            e_drain: begin
               if (drain_q == '0) begin
                  state_q <= e_idle;
               end else begin
                  drain_q <= drain_q - drain_w_lp'(1);
               end
            end
            default: state_q <= e_idle;
         endcase
      end
   end

   // Redirect and stall come straight from the state register; flush also
   // fires combinationally in the detection cycle.
   assign redirect_v_o   = (state_q == e_redirect);
   assign redirect_npc_o = target_q;
   assign stall_o        = ~idle;
   assign flush_o        = mispredict_inc | (state_q == e_redirect);

   bp_be_sat_counter #(.width_p(ctr_width_p)) branch_ctr (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inc_i     (branch_inc),
      .count_o   (branch_count_o)
   );

   bp_be_sat_counter #(.width_p(ctr_width_p)) mispredict_ctr (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inc_i     (mispredict_inc),
      .count_o   (mispredict_count_o)
   );

endmodule
